// File: rtl/system_0_sysid_pkg.sv
// Shared types and constants for the system ID / timestamp checker.
package system_0_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    DONE
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_TS = 32'd1720305019;

  localparam int CNT_W = 16;

endpackage

// File: rtl/system_0_sysid_timeout_cnt.sv
// Stall counter; expires on a stall cycle once limit stalls were tolerated.
module system_0_sysid_timeout_cnt
  import system_0_sysid_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count == limit);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/system_0_sysid_checker.sv
// Reads the system ID and timestamp over Avalon-MM and compares them
// against the values this build expects.
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_TS,
  parameter int          TIMEOUT_CYCLES     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state, state_nxt;
  logic   cnt_clear;
  logic   cnt_en;
  logic   expired;
  logic   cap_id;
  logic   cap_ts;
  logic   abort;
  logic   launch;

  system_0_sysid_timeout_cnt u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b1;
    cnt_en    = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RD_ID;
      end
      RD_ID: begin
        cnt_clear = 1'b0;
        cnt_en    = avm_waitrequest;
        if (!avm_waitrequest) begin
          state_nxt = RD_TS;
          cnt_clear = 1'b1;
          cap_id    = 1'b1;
        end else if (expired) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      RD_TS: begin
        cnt_clear = 1'b0;
        cnt_en    = avm_waitrequest;
        if (!avm_waitrequest) begin
          state_nxt = DONE;
          cap_ts    = 1'b1;
        end else if (expired) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      DONE: begin
        state_nxt = start ? RD_ID : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign launch = start && (state == IDLE || state == DONE);

  assign avm_read    = (state == RD_ID) || (state == RD_TS);
  assign avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy        = avm_read;
  assign done        = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset || launch) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (abort) timeout <= 1'b1;
    end
  end

endmodule
